usb_tx_shifter: RTL and testbench

Serializes one assembled packet word onto the USB-style differential line. Sits directly downstream of the packet combiner: on a start strobe it captures the 88-bit shift word and the packet-type select. It then transmits a SYNC field, the packet bits LSB first with NRZI encoding and bit stuffing, and an end-of-packet (EOP) sequence. All line activity is paced by a one-clock-wide bit-rate tick, so the bit rate is set outside this block.

---
 rtl/usb_tx_shifter.sv | 184 ++++++++++++++++++
 tb/tb_usb_tx_shifter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_shifter.sv
// Serializes one captured packet word onto the D+/D- line: SYNC, NRZI data with
// bit stuffing (LSB first), then SE0/SE0/J end-of-packet, paced by bit_en.
module usb_tx_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic [87:0] shift_data,
    input  logic [2:0]  data_sel,
    input  logic        ready,
    input  logic        start,
    input  logic        bit_en,
    output logic        d_plus,
    output logic        d_minus,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP1,
        EOP2,
        EOPJ
    } state_t;

    state_t state;
    state_t state_next;

    logic [87:0] word;
    logic [6:0]  len;
    logic [6:0]  bit_idx;
    logic [2:0]  ones;

    logic [6:0]  len_sel;
    logic        sel_ok;
    logic        accept;
    logic        tx_bit;
    logic        last_bit;

    logic        dp_next;
    logic        dm_next;
    logic [6:0]  idx_next;
    logic [2:0]  ones_next;

    always_comb begin
        len_sel = '0;
        sel_ok  = 1'b1;
        case (data_sel)
            3'b010:         len_sel = 7'd8;
            3'b000, 3'b011: len_sel = 7'd24;
            3'b001:         len_sel = 7'd88;
            default:        sel_ok  = 1'b0;
        endcase
    end

    assign accept   = (state == IDLE) && start && ready && sel_ok;
    assign last_bit = (bit_idx == len - 7'd1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; tx_bit is the bit this state puts on the line at the next tick
    always_comb begin
        state_next = state;
        tx_bit     = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                tx_bit = (bit_idx == 7'd7);
                if (bit_en && bit_idx == 7'd7) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_bit = word[bit_idx];
                if (bit_en) begin
                    // A sixth consecutive one forces a stuff bit, even after the last data bit
                    if (tx_bit && ones == 3'd5) begin
                        state_next = STUFF;
                    end else if (last_bit) begin
                        state_next = EOP1;
                    end
                end
            end
            STUFF: begin
                tx_bit = 1'b0;
                if (bit_en) begin
                    state_next = (bit_idx == len) ? EOP1 : DATA;
                end
            end
            EOP1: begin
                if (bit_en) begin
                    state_next = EOP2;
                end
            end
            EOP2: begin
                if (bit_en) begin
                    state_next = EOPJ;
                end
            end
            EOPJ: begin
                if (bit_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: values the line and counters take at the next tick
    always_comb begin
        dp_next   = d_plus;
        dm_next   = d_minus;
        idx_next  = bit_idx;
        ones_next = ones;
        case (state)
            SYNC, DATA, STUFF: begin
                // NRZI: a zero swaps J and K, a one holds the level
                if (!tx_bit) begin
                    dp_next = d_minus;
                    dm_next = d_plus;
                end
                ones_next = tx_bit ? ones + 3'd1 : 3'd0;
                if (state == SYNC) begin
                    idx_next = (bit_idx == 7'd7) ? 7'd0 : bit_idx + 7'd1;
                end else if (state == DATA) begin
                    idx_next = bit_idx + 7'd1;
                end
            end
            EOP1, EOP2: begin
                dp_next = 1'b0;
                dm_next = 1'b0;
            end
            EOPJ: begin
                dp_next = 1'b1;
                dm_next = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word    <= '0;
            len     <= '0;
            bit_idx <= '0;
            ones    <= '0;
            d_plus  <= 1'b1;
            d_minus <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                word    <= shift_data;
                len     <= len_sel;
                bit_idx <= '0;
                ones    <= '0;
                busy    <= 1'b1;
            end else if (bit_en && state != IDLE) begin
                d_plus  <= dp_next;
                d_minus <= dm_next;
                bit_idx <= idx_next;
                ones    <= ones_next;
                if (state == EOPJ) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_shifter.sv
// Randomized bench for usb_tx_shifter: a bit-list reference model predicts every
// line symbol, and an NRZI/destuff decoder recovers the payload from the line.
module tb_usb_tx_shifter;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic        clk = 1'b0;
    logic        rst;
    logic [87:0] shift_data;
    logic [2:0]  data_sel;
    logic        ready;
    logic        start;
    logic        bit_en;
    logic        d_plus;
    logic        d_minus;
    logic        busy;
    logic        done;
    logic [1:0]  line;

    int n_checks = 0;
    int n_errors = 0;
    int model_stuffs;
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];

    assign line = {d_plus, d_minus};

    usb_tx_shifter dut (
        .clk        (clk),
        .rst        (rst),
        .shift_data (shift_data),
        .data_sel   (data_sel),
        .ready      (ready),
        .start      (start),
        .bit_en     (bit_en),
        .d_plus     (d_plus),
        .d_minus    (d_minus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int len_of(input logic [2:0] sel);
        case (sel)
            3'b010:         return 8;
            3'b000, 3'b011: return 24;
            3'b001:         return 88;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [87:0] rand88();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[87:0];
    endfunction

    // Bit list: SYNC, payload with a 0 inserted after every run of six 1s, then NRZI, then EOP
    task automatic build_model(input logic [87:0] d, input int n);
        bit         bits[$];
        int         run;
        logic [1:0] lvl;
        bits.delete();
        for (int i = 0; i < 7; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        run = 1;
        model_stuffs = 0;
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[i]);
            run = d[i] ? run + 1 : 0;
            if (run == 6) begin
                bits.push_back(1'b0);
                run = 0;
                model_stuffs++;
            end
        end
        exp_q.delete();
        lvl = J;
        foreach (bits[i]) begin
            if (!bits[i]) lvl = (lvl == J) ? K : J;
            exp_q.push_back(lvl);
        end
        exp_q.push_back(SE0);
        exp_q.push_back(SE0);
        exp_q.push_back(J);
    endtask

    task automatic decode(input int n, output logic [87:0] rec, output int max_run, output int bad);
        logic [1:0] prev;
        int         run;
        int         idx;
        int         items;
        bit         b;
        bit         skip;
        prev = J; run = 0; idx = 0; rec = '0; max_run = 0; bad = 0; skip = 1'b0;
        items = obs_q.size() - 3;
        for (int i = 0; i < items; i++) begin
            b = (obs_q[i] == prev);
            prev = obs_q[i];
            run = b ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (i < 8) continue;
            if (skip) begin
                skip = 1'b0;
                if (b) bad++;
                continue;
            end
            if (idx < n) rec[idx] = b;
            idx++;
            if (run == 6) skip = 1'b1;
        end
        if (idx != n) bad++;
    endtask

    // One packet: accept (unless already accepted), then tick through every expected symbol
    task automatic play(input logic [87:0] data, input logic [2:0] sel, input bit pre, input bit poke,
                        input bit hold, input logic [87:0] nd, input logic [2:0] ns, output int dt);
        int         n;
        int         gap;
        int         mid;
        logic [1:0] prev;
        build_model(data, len_of(sel));
        n = exp_q.size();
        mid = n / 2;
        obs_q.delete();
        dt = 0;
        if (!pre) begin
            shift_data = data; data_sel = sel; ready = 1'b1; start = 1'b1;
            bit_en = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        bit_en = 1'b0;
        check("accept_busy", 96'(busy), 96'(1'b1));
        check("accept_line", 96'(line), 96'(J));
        check("accept_done", 96'(done), 96'(1'b0));
        if (hold) begin
            start = 1'b1; ready = 1'b1; shift_data = nd; data_sel = ns;
        end else begin
            start = 1'b0; shift_data = rand88(); data_sel = 3'($urandom); ready = 1'($urandom);
        end
        prev = J;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                if (poke && k == mid && g == 0) begin
                    start = 1'b1; ready = 1'b1; data_sel = 3'b010; shift_data = rand88();
                end
                @(posedge clk); #1;
                start = hold;
                check("hold_line", 96'(line), 96'(prev));
            end
            bit_en = 1'b1;
            @(posedge clk); #1;
            bit_en = 1'b0;
            obs_q.push_back(line);
            check("sym", 96'(line), 96'(exp_q[k]));
            check("busy", 96'(busy), 96'(k != n - 1));
            check("done", 96'(done), 96'(k == n - 1));
            if (done && dt == 0) dt = k + 1;
            prev = exp_q[k];
        end
        if (!hold) begin
            @(posedge clk); #1;
            check("done_pulse", 96'(done), 96'(1'b0));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [87:0] d;
        logic [87:0] rec;
        logic [2:0]  sel;
        logic [2:0]  sels[4];
        logic [2:0]  rej[3];
        int          dt;
        int          max_run;
        int          bad;

        sels = '{3'b010, 3'b000, 3'b011, 3'b001};
        rej  = '{3'b100, 3'b101, 3'b111};
        rst = 1'b0; start = 1'b0; ready = 1'b0; bit_en = 1'b0;
        shift_data = '0; data_sel = '0;
        #12;
        check("rst_line", 96'(line), 96'(J));
        check("rst_busy", 96'(busy), 96'(1'b0));
        check("rst_done", 96'(done), 96'(1'b0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Handshake 0xC3: 19 ticks to done
        play(88'hC3, 3'b010, 1'b0, 1'b0, 1'b0, '0, '0, dt);
        check("hs_ticks", 96'(dt), 96'(19));

        // Token all ones: four stuffs, 39 ticks
        play(88'hFFFFFF, 3'b011, 1'b0, 1'b0, 1'b0, '0, '0, dt);
        check("tok_ticks", 96'(dt), 96'(39));
        check("tok_stuffs", 96'(model_stuffs), 96'(4));
        decode(24, rec, max_run, bad);
        check("tok_rec", 96'(rec), 96'(88'hFFFFFF));
        check("tok_max_ones", 96'(max_run), 96'(6));
        check("tok_stuff_bits", 96'(bad), 96'(0));

        // Data packet with a mid-packet start pulse that must be ignored
        d = {16'h1234, 64'h0123456789ABCDEF, 8'h4B};
        play(d, 3'b001, 1'b0, 1'b1, 1'b0, '0, '0, dt);
        check("data_ticks", 96'(dt), 96'(8 + 88 + model_stuffs + 3));
        decode(88, rec, max_run, bad);
        check("data_rec", 96'(rec), 96'(d));
        check("data_stuff_bits", 96'(bad), 96'(0));

        // Rejected starts: bad packet types and ready low
        for (int r = 0; r < 4; r++) begin
            shift_data = rand88(); start = 1'b1;
            ready = (r < 3); data_sel = (r < 3) ? rej[r] : 3'b010;
            @(posedge clk); #1;
            start = 1'b0;
            for (int t = 0; t < 3; t++) begin
                bit_en = 1'b1;
                @(posedge clk); #1;
                bit_en = 1'b0;
                check("rej_busy", 96'(busy), 96'(1'b0));
                check("rej_line", 96'(line), 96'(J));
            end
        end

        // Asynchronous reset during DATA, then a clean handshake
        shift_data = 88'hFFFFFF; data_sel = 3'b011; ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin
            bit_en = 1'b1;
            @(posedge clk); #1;
            bit_en = 1'b0;
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        check("mid_rst_line", 96'(line), 96'(J));
        check("mid_rst_busy", 96'(busy), 96'(1'b0));
        check("mid_rst_done", 96'(done), 96'(1'b0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_line", 96'(line), 96'(J));
        play(88'hC3, 3'b010, 1'b0, 1'b0, 1'b0, '0, '0, dt);
        check("post_rst_ticks", 96'(dt), 96'(19));

        // Back-to-back with start held: second packet accepted in the done cycle
        d = rand88();
        play(88'h5A, 3'b010, 1'b0, 1'b0, 1'b1, d, 3'b000, dt);
        check("b2b_done_line", 96'(line), 96'(J));
        play(d, 3'b000, 1'b1, 1'b0, 1'b0, '0, '0, dt);
        check("b2b_ticks", 96'(dt), 96'(8 + 24 + model_stuffs + 3));

        // Randomized packets
        for (int p = 0; p < 16; p++) begin
            sel = sels[$urandom_range(0, 3)];
            case ($urandom_range(0, 2))
                0:       d = rand88();
                1:       d = rand88() | rand88() | rand88();
                default: d = '1;
            endcase
            play(d, sel, 1'b0, 1'(p % 3 == 0), 1'b0, '0, '0, dt);
            check("rnd_ticks", 96'(dt), 96'(8 + len_of(sel) + model_stuffs + 3));
            decode(len_of(sel), rec, max_run, bad);
            check("rnd_rec", 96'(rec), 96'(d & ((88'd1 << len_of(sel)) - 88'd1)));
            check("rnd_stuff_bits", 96'(bad), 96'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
